// File: rtl/cpu_prog_mem.sv
// rtl/cpu_prog_mem.sv - register-based CPU program memory with a bit-serial program loader
//
// Purpose:
//   Answers the CPU instruction fetch combinationally (data follows addr with
//   zero latency). A serial loader lets a host rewrite the whole program
//   after reset: bits arrive MSB first, one word per DATA_W valid bits, and
//   words fill from address 0 up to the last address.
//
// Ports:
//   clk       in   1       system clock, rising edge
//   n_rst     in   1       asynchronous active-low reset
//   addr      in   ADDR_W  fetch address from the CPU
//   data      out  DATA_W  instruction word (NOP_WORD while a load runs)
//   ld_start  in   1       start or restart a program load
//   ld_valid  in   1       ld_bit is valid this cycle
//   ld_bit    in   1       serial program bit, MSB of each word first
//   ld_busy   out  1       a load is in progress
//   ld_done   out  1       one-cycle pulse when a load completes
//   ld_ptr    out  ADDR_W  word currently being loaded
//   ld_err    out  1       sticky parity error
//
// Build option:
//   CPU_PROG_MEM_PARITY_EN - when defined, every word is followed by an
//   even-parity bit; a word whose parity bit mismatches is dropped (the
//   pointer still advances) and ld_err is set until reset or the next
//   ld_start. When undefined there is no parity slot and ld_err is 0.

module cpu_prog_mem #(
    parameter int              ADDR_W    = 1,
    parameter int              DATA_W    = 1,
    parameter logic [DATA_W-1:0] INIT_WORD = '0,
    parameter logic [DATA_W-1:0] NOP_WORD  = '0
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data,
    input  logic              ld_start,
    input  logic              ld_valid,
    input  logic              ld_bit,
    output logic              ld_busy,
    output logic              ld_done,
    output logic [ADDR_W-1:0] ld_ptr,
    output logic              ld_err
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int CNT_W = $clog2(DATA_W + 1);

    // Index of the serial slot that completes a word: the parity bit when
    // parity is enabled, otherwise the last data bit.
`ifdef CPU_PROG_MEM_PARITY_EN
    localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(DATA_W);
`else
    localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(DATA_W - 1);
`endif

    localparam logic [ADDR_W-1:0] LAST_PTR = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] shift;
    logic [CNT_W-1:0]  bit_cnt;

    // Shift register with the incoming bit appended; its low DATA_W bits are
    // both the next shift value and, on the last data bit, the finished word.
    // This form stays valid for DATA_W = 1, where the word is just ld_bit.
    logic [DATA_W:0]   shift_cat;
    logic              unused_shift_msb;

    logic              bit_take;
    logic              slot_last;
    logic              word_ok;
    logic [DATA_W-1:0] word_val;

    assign shift_cat        = {shift, ld_bit};
    assign unused_shift_msb = shift_cat[DATA_W];

    // A start in the same cycle as a valid bit wins; the bit is discarded.
    assign bit_take  = (state == LOAD) && ld_valid && !ld_start;
    assign slot_last = bit_take && (bit_cnt == LAST_SLOT);

`ifdef CPU_PROG_MEM_PARITY_EN
    // Even parity: the parity bit equals the XOR of the data bits.
    assign word_val = shift;
    assign word_ok  = ((^shift) == ld_bit);
`else
    assign word_val = shift_cat[DATA_W-1:0];
    assign word_ok  = 1'b1;
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (ld_start) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                if (ld_start) begin
                    state_nxt = LOAD;
                end else if (slot_last && (ld_ptr == LAST_PTR)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                // A start here goes straight back into a new load.
                if (ld_start) begin
                    state_nxt = LOAD;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Loader datapath and memory array
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= INIT_WORD;
            end
            ld_ptr  <= '0;
            bit_cnt <= '0;
            shift   <= '0;
        end else if (ld_start) begin
            // Start or restart: the partial word is dropped, but words
            // already written during an interrupted load stay written.
            ld_ptr  <= '0;
            bit_cnt <= '0;
            shift   <= '0;
        end else if (bit_take) begin
            if (slot_last) begin
                // Whole-word write only; a bad-parity word is skipped but
                // still consumes its address.
                if (word_ok) begin
                    mem[ld_ptr] <= word_val;
                end
                ld_ptr  <= ld_ptr + ADDR_W'(1);
                bit_cnt <= '0;
                shift   <= '0;
            end else begin
                shift   <= shift_cat[DATA_W-1:0];
                bit_cnt <= bit_cnt + CNT_W'(1);
            end
        end
    end

`ifdef CPU_PROG_MEM_PARITY_EN
    logic err_q;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            err_q <= 1'b0;
        end else if (ld_start) begin
            err_q <= 1'b0;
        end else if (slot_last && !word_ok) begin
            err_q <= 1'b1;
        end
    end

    assign ld_err = err_q;
`else
    assign ld_err = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign ld_busy = (state == LOAD);
    assign ld_done = (state == DONE);

    // Zero-latency fetch; the array is hidden while it is being rewritten.
    assign data = (state == LOAD) ? NOP_WORD : mem[addr];

endmodule

// File: doc/cpu_prog_mem.md
Name: cpu_prog_mem

Overview:
- Program memory that answers the CPU's instruction fetch: the CPU drives `addr`, this block returns the instruction word on `data`.
- Includes a bit-serial loader, so a bench or host can write a new program after reset without recompiling.
- Sits beside `cpu` at top level and connects to its `addr` output and `data` input.
- The array is register-based, so it is sized for small programs.

Parameters:
- ADDR_W, 1, fetch address width; depth = 2**ADDR_W words.
- DATA_W, 1, instruction word width.
- INIT_WORD, 0, value every word takes on reset.
- NOP_WORD, 0, value presented on `data` while a load is in progress.

Ports:
- clk  in  1  system clock, rising edge.
- n_rst  in  1  asynchronous active-low reset.
- addr  in  ADDR_W  fetch address from the CPU.
- data  out  DATA_W  instruction word to the CPU.
- ld_start  in  1  start or restart a program load.
- ld_valid  in  1  `ld_bit` is valid this cycle.
- ld_bit  in  1  serial program bit, MSB of each word first.
- ld_busy  out  1  a load is in progress.
- ld_done  out  1  one-cycle pulse when a load completes.
- ld_ptr  out  ADDR_W  word currently being loaded.
- ld_err  out  1  sticky parity error; tied to 0 unless CPU_PROG_MEM_PARITY_EN is defined.

Behaviour:
- Reset is asynchronous and active-low. While n_rst=0:
  - every memory word = INIT_WORD;
  - state = IDLE;
  - ld_busy=0, ld_done=0, ld_ptr=0, ld_err=0;
  - bit counter and shift register = 0.
- Fetch path:
  - `data` is combinational from `addr`: data = mem[addr] when state is IDLE or DONE.
  - `data` = NOP_WORD when state is LOAD.
  - Zero latency, since the CPU samples `data` in the same cycle it drives `addr`.
- State machine:
  - IDLE -> LOAD on ld_start=1. On entry, ld_ptr=0 and bit count=0.
  - LOAD: on each cycle with ld_valid=1, shift ld_bit into the shift register and increment the bit count.
  - When the DATA_W-th bit arrives, the same clock edge writes mem[ld_ptr] = {shift[DATA_W-2:0], ld_bit}, increments ld_ptr and clears the bit count.
  - The write to the last word (ld_ptr = 2**ADDR_W-1) moves the state to DONE, and ld_ptr wraps to 0.
  - DONE -> IDLE after exactly 1 cycle. ld_done=1 only in DONE.
  - ld_busy=1 only in LOAD.
- Boundary conditions:
  - ld_valid=0 in LOAD: hold; no timeout.
  - ld_valid or ld_bit in IDLE or DONE: ignored.
  - ld_start in LOAD: restart. ld_ptr=0, partial word discarded, already-written words keep their new values.
  - ld_start in DONE: go to LOAD, not IDLE.
  - ld_start and ld_valid in the same cycle: the start wins and the bit is discarded.
  - Reset mid-load: full reset, including memory back to INIT_WORD.
  - A word is never partially written.
- Width rules:
  - ld_ptr is ADDR_W bits and wraps modulo the depth.
  - The bit counter is $clog2(DATA_W+1) bits, which also covers the parity slot.
  - When DATA_W=1, each valid bit is one word.

Optional Feature:
- Macro name: CPU_PROG_MEM_PARITY_EN.
- Defined:
  - Each word is followed by one extra serial bit, its even-parity bit (XOR of the DATA_W data bits).
  - The word is written on the parity-bit edge, not the last data-bit edge.
  - On a parity mismatch, the word is not written, ld_ptr still advances, and ld_err sets to 1.
  - ld_err clears only on reset or on the next ld_start.
- Undefined:
  - There is no parity slot and ld_err is constant 0.

Test Plan:
- Reset with ADDR_W=2, DATA_W=4, INIT_WORD=4'h0 -> data=4'h0 for addr 0..3; ld_busy=0, ld_done=0.
- Load the words 3, A, F, 5 (16 bits, MSB first, ld_valid held high) -> ld_busy=1 and data=NOP_WORD throughout; ld_done pulses for one cycle 16 cycles after the first bit; then addr 0..3 read 3, A, F, 5.
- Same load with ld_valid toggling 1/0 every cycle -> identical final contents; ld_done occurs 31 cycles after the first bit.
- Send 6 bits, pulse ld_start, then load 9, 9, 9, 9 -> ld_ptr returns to 0; all words read 9; no stray write from the discarded bits.
- Pull n_rst low after 2 words are loaded -> all words read 0, ld_busy=0 immediately (asynchronous); a later full load succeeds.
- With CPU_PROG_MEM_PARITY_EN and word 1's parity bit flipped -> word 1 keeps its old value, words 0, 2, 3 are updated, ld_err=1 until the next ld_start.
